ternary_matrix_deserializer: RTL and testbench

- Receives a ternary weight matrix as a valid/ready stream of packed 2-bit ternary codes and assembles a full `ternary_matrix_t`.
- Presents the assembled matrix to the matmul datapath with its own valid/ready handshake.
- Write-side counterpart of the DV matrix dump/generate helpers: element order on the stream equals dump order `m[i][j]`, with i outer and j inner.
- Sits between the host/DMA weight stream and the AFU weight register.

---
 rtl/config_pkg.sv | 30 +++
 rtl/ternary_matrix_deserializer_decoder.sv | 26 ++
 rtl/ternary_matrix_deserializer.sv | 110 +++++++++++
 tb/tb_ternary_matrix_deserializer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared ternary weight types plus the code decoder used by every ternary
// stream unit. The deserializer FSM state type lives here as well.
package config_pkg;

    localparam int D = 4;

    typedef logic signed [1:0] ternary_t;
    typedef ternary_t [D-1:0][D-1:0] ternary_matrix_t;

    localparam logic [1:0] TernaryIllegal = 2'b10;

    typedef struct packed {
        ternary_t val;
        logic     illegal;
    } ternary_dec_t;

    typedef enum logic [0:0] {
        DesLoad = 1'b0,
        DesFull = 1'b1
    } des_state_e;

    // The -2 encoding has no ternary meaning; it decodes to 0 and is flagged.
    function automatic ternary_dec_t ternary_decode(input logic [1:0] code);
        ternary_dec_t r;
        r.illegal = (code == TernaryIllegal);
        r.val     = r.illegal ? ternary_t'(2'b00) : ternary_t'(code);
        return r;
    endfunction

endpackage

// File: rtl/ternary_matrix_deserializer_decoder.sv
// Combinational decode of one stream beat into ternary elements plus a
// beat-level illegal-code flag.
module ternary_beat_decoder
    import config_pkg::*;
#(
    parameter int ElemsPerBeat = 8
) (
    input  logic [2*ElemsPerBeat-1:0]  beat_i,
    output ternary_t [ElemsPerBeat-1:0] elems_o,
    output logic                        illegal_o
);

    ternary_dec_t dec;

    always_comb begin
        elems_o   = '0;
        illegal_o = 1'b0;
        dec       = '0;
        for (int e = 0; e < ElemsPerBeat; e++) begin
            dec        = ternary_decode(beat_i[2*e +: 2]);
            elems_o[e] = dec.val;
            illegal_o  = illegal_o | dec.illegal;
        end
    end

endmodule

// File: rtl/ternary_matrix_deserializer.sv
// Assembles a ternary weight matrix from a stream of packed 2-bit codes
// (row-major, i outer / j inner) and hands it to the matmul datapath.
module ternary_matrix_deserializer
    import config_pkg::*;
#(
    parameter int ElemsPerBeat = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [2*ElemsPerBeat-1:0] in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output ternary_matrix_t           out_matrix_o,
    output logic                      out_err_o
);

    localparam int BeatW    = 2 * ElemsPerBeat;
    localparam int NumBeats = (D * D) / ElemsPerBeat;
    localparam int CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int IdxW     = (D > 1) ? $clog2(D) : 1;

    if (((D * D) % ElemsPerBeat) != 0) begin : g_cfg_check
        $error("D*D must be a multiple of ElemsPerBeat");
    end

    des_state_e                 state_q, state_d;
    logic [CntW-1:0]            beat_cnt_q, beat_cnt_d;
    ternary_matrix_t            matrix_q, matrix_d;
    logic                       err_q, err_d;

    ternary_t [ElemsPerBeat-1:0] beat_elems;
    logic                        beat_illegal;
    int                          flat_idx;
    logic [IdxW-1:0]             row_idx, col_idx;

    ternary_beat_decoder #(
        .ElemsPerBeat(ElemsPerBeat)
    ) u_decoder (
        .beat_i   (in_data_i[BeatW-1:0]),
        .elems_o  (beat_elems),
        .illegal_o(beat_illegal)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        matrix_d   = matrix_q;
        err_d      = err_q;
        flat_idx   = 0;
        row_idx    = '0;
        col_idx    = '0;
        unique case (state_q)
            DesLoad: begin
                // Flush wins over a beat handshake in the same cycle.
                if (flush_i) begin
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                end else if (in_valid_i) begin
                    for (int e = 0; e < ElemsPerBeat; e++) begin
                        flat_idx = int'(beat_cnt_q) * ElemsPerBeat + e;
                        row_idx  = IdxW'(flat_idx / D);
                        col_idx  = IdxW'(flat_idx % D);
                        matrix_d[row_idx][col_idx] = beat_elems[e];
                    end
                    err_d = err_q | beat_illegal;
                    if (beat_cnt_q == CntW'(NumBeats - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = DesFull;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DesFull: begin
                // The matrix register is left alone; the next load overwrites every element.
                if (out_ready_i) begin
                    state_d = DesLoad;
                    err_d   = 1'b0;
                end
            end
            default: state_d = DesLoad;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= DesLoad;
            beat_cnt_q <= '0;
            matrix_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            matrix_q   <= matrix_d;
            err_q      <= err_d;
        end
    end

    assign in_ready_o   = (state_q == DesLoad);
    assign out_valid_o  = (state_q == DesFull);
    assign out_err_o    = (state_q == DesFull) && err_q;
    assign out_matrix_o = matrix_q;

    a_matrix_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i) |=> $stable(out_matrix_o));

endmodule

// File: tb/tb_ternary_matrix_deserializer.sv
// Directed and randomized checks of the ternary matrix deserializer (D=4, 8 elements per beat).
module tb_ternary_matrix_deserializer;
    import config_pkg::*;

    localparam int EPB       = 8;
    localparam int BEAT_W    = 2 * EPB;
    localparam int NUM_BEATS = (D * D) / EPB;
    localparam int N_RAND    = 200;

    typedef ternary_t [D-1:0] trow_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    ternary_matrix_t   out_matrix;
    logic              out_err;

    int n_checks = 0;
    int n_errors = 0;

    ternary_matrix_t exp_m;
    ternary_matrix_t exp_q[$];

    always #5 clk = ~clk;

    ternary_matrix_deserializer #(.ElemsPerBeat(EPB)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_matrix_o(out_matrix),
        .out_err_o   (out_err)
    );

    a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> $stable(in_data));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic trow_t row(input int a, input int b, input int c, input int d);
        trow_t r;
        r[0] = ternary_t'(a);
        r[1] = ternary_t'(b);
        r[2] = ternary_t'(c);
        r[3] = ternary_t'(d);
        return r;
    endfunction

    function automatic ternary_matrix_t mat(input trow_t r0, input trow_t r1, input trow_t r2, input trow_t r3);
        ternary_matrix_t m;
        m[0] = r0;
        m[1] = r1;
        m[2] = r2;
        m[3] = r3;
        return m;
    endfunction

    // Inverse of the DUT: element k of the matrix goes to beat k/EPB, slot k%EPB.
    task automatic pack_ternary_matrix(input ternary_matrix_t m, output logic [BEAT_W-1:0] beats [NUM_BEATS]);
        for (int b = 0; b < NUM_BEATS; b++) beats[b] = '0;
        for (int k = 0; k < D * D; k++)
            beats[k / EPB][2*(k % EPB) +: 2] = m[k / D][k % D];
    endtask

    function automatic ternary_matrix_t random_ternary_matrix();
        ternary_matrix_t m;
        int r;
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                r = int'($urandom_range(0, 2));
                m[i][j] = (r == 0) ? ternary_t'(0) : (r == 1) ? ternary_t'(1) : ternary_t'(-1);
            end
        return m;
    endfunction

    task automatic send_beat(input logic [BEAT_W-1:0] b, input string tag);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_data  = b;
        n        = 0;
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 1000);
        if (!acc) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin : main
        logic [BEAT_W-1:0] beats [NUM_BEATS];
        ternary_matrix_t   m_a, m_b, m_ill, m_fresh, m_rnd, got_m;
        int                got, cyc;

        m_a     = mat(row(-1, 1, -1, 1), row(1, -1, 1, -1), row(1, 0, 1, 0), row(-1, 0, -1, 0));
        m_b     = mat(row(0, -1, -1, 0), row(1, -1, 1, 0), row(0, 0, -1, -1), row(1, 1, 0, -1));
        m_ill   = mat(row(0, 1, -1, 1), row(1, -1, 1, -1), row(1, 0, 1, 0), row(-1, 0, -1, 0));
        m_fresh = mat(row(1, 0, 1, 0), row(1, 0, 1, 0), row(-1, 0, -1, 0), row(-1, 0, -1, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_matrix", out_matrix, 0);
        #3 rst_n = 1'b1;
        step();

        // Basic load with in_valid held and consumer always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hDD77;
        step();
        chk("basic_mid_valid", out_valid, 0);
        chk("basic_mid_ready", in_ready, 1);
        in_data = 16'h3311;
        step();
        in_valid = 1'b0;
        chk("basic_valid", out_valid, 1);
        chk("basic_ready_low", in_ready, 0);
        chk("basic_matrix", out_matrix, m_a);
        chk("basic_err", out_err, 0);
        step();
        chk("basic_handoff_ready", in_ready, 1);
        chk("basic_handoff_valid", out_valid, 0);

        // Back-pressure held for 10 cycles in FULL
        out_ready = 1'b0;
        send_beat(16'h1D3C, "bp0");
        send_beat(16'hC5F0, "bp1");
        for (int c = 0; c < 10; c++) begin
            chk("bp_flags", {in_ready, out_valid}, 2'b01);
            chk("bp_matrix", out_matrix, m_b);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", {in_ready, out_valid}, 2'b10);

        // Illegal code in element 0, then a clean matrix
        send_beat(16'hDD76, "ill0");
        send_beat(16'h3311, "ill1");
        chk("ill_valid", out_valid, 1);
        chk("ill_matrix", out_matrix, m_ill);
        chk("ill_err", out_err, 1);
        step();
        send_beat(16'hDD77, "clean0");
        send_beat(16'h3311, "clean1");
        chk("clean_matrix", out_matrix, m_a);
        chk("clean_err", out_err, 0);
        step();

        // Flush after one beat (carrying an illegal code), with a dropped beat in the flush cycle
        send_beat(16'hFFFE, "fl_partial");
        in_valid = 1'b1;
        in_data  = 16'h5555;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_after_flush", out_valid, 0);
        send_beat(16'h1111, "fl_fresh0");
        chk("fl_restart_cnt", out_valid, 0);
        out_ready = 1'b0;
        send_beat(16'h3333, "fl_fresh1");
        chk("fl_valid", out_valid, 1);
        chk("fl_matrix", out_matrix, m_fresh);
        chk("fl_err", out_err, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_full_valid", out_valid, 1);
        chk("fl_full_matrix", out_matrix, m_fresh);
        out_ready = 1'b1;
        step();
        chk("fl_full_release", {in_ready, out_valid}, 2'b10);

        // Asynchronous reset between clock edges during a load
        send_beat(16'h7777, "ar_partial");
        #3 rst_n = 1'b0;
        #1;
        chk("ar_in_ready", in_ready, 1);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_matrix", out_matrix, 0);
        #2 rst_n = 1'b1;
        send_beat(16'h1111, "ar_b0");
        chk("ar_needs_all_beats", out_valid, 0);
        send_beat(16'h3333, "ar_b1");
        chk("ar_valid", out_valid, 1);
        chk("ar_matrix_full", out_matrix, m_fresh);
        step();

        // Random traffic against a scoreboard
        out_ready = 1'b0;
        fork
            begin : producer
                logic [BEAT_W-1:0] pb [NUM_BEATS];
                for (int t = 0; t < N_RAND; t++) begin
                    m_rnd = random_ternary_matrix();
                    exp_q.push_back(m_rnd);
                    pack_ternary_matrix(m_rnd, pb);
                    for (int b = 0; b < NUM_BEATS; b++) begin
                        repeat ($urandom_range(0, 2)) step();
                        send_beat(pb[b], "rnd_beat");
                    end
                end
            end
            begin : consumer
                got = 0;
                cyc = 0;
                while (got < N_RAND && cyc < 20000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("rnd_extra_matrix", 64'd1, 64'd0);
                        end else begin
                            got_m = exp_q.pop_front();
                            chk("rnd_matrix", out_matrix, got_m);
                            chk("rnd_err", out_err, 0);
                        end
                        got++;
                    end
                    step();
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        chk("rnd_count", got, N_RAND);
        chk("rnd_leftover", exp_q.size(), 0);
        repeat (3) step();
        chk("rnd_no_dup", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
